// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execute stage: default widths, the op encoding and op-class helpers.
// Every producer and consumer of the issue/result interfaces imports this package.
package alu_exec_unit_pkg;

    localparam int PKG_DATA_W    = 32;
    localparam int PKG_ADDR_W    = 32;
    localparam int PKG_ROB_IDX_W = 4;
    localparam int PKG_OP_W      = 6;

    // Encoding 0 and 30..63 are undefined; they retire as a no-op with PC+4.
    typedef enum logic [PKG_OP_W-1:0] {
        OP_ADD   = 6'd1,  OP_SUB   = 6'd2,  OP_AND   = 6'd3,  OP_OR    = 6'd4,
        OP_XOR   = 6'd5,  OP_SLL   = 6'd6,  OP_SRL   = 6'd7,  OP_SRA   = 6'd8,
        OP_SLT   = 6'd9,  OP_SLTU  = 6'd10, OP_ADDI  = 6'd11, OP_ANDI  = 6'd12,
        OP_ORI   = 6'd13, OP_XORI  = 6'd14, OP_SLLI  = 6'd15, OP_SRLI  = 6'd16,
        OP_SRAI  = 6'd17, OP_SLTI  = 6'd18, OP_SLTIU = 6'd19, OP_LUI   = 6'd20,
        OP_AUIPC = 6'd21, OP_JAL   = 6'd22, OP_JALR  = 6'd23, OP_BEQ   = 6'd24,
        OP_BNE   = 6'd25, OP_BLT   = 6'd26, OP_BGE   = 6'd27, OP_BLTU  = 6'd28,
        OP_BGEU  = 6'd29
    } op_e;

    function automatic logic uses_imm(input op_e op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
                          OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU};
    endfunction

    function automatic logic is_branch(input op_e op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

endpackage

// File: rtl/alu_exec_comb.sv
// Combinational RV32I integer/branch datapath: op + operands -> result, branch outcome, next PC.
module alu_exec_comb
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int OP_W   = PKG_OP_W
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_result,
    output logic              o_jump,
    output logic [ADDR_W-1:0] o_jump_addr
);
    localparam int SHAMT_W = $clog2(DATA_W);

    op_e                      w_op;
    logic        [DATA_W-1:0] w_b;
    logic signed [DATA_W-1:0] w_rs1_s;
    logic signed [DATA_W-1:0] w_rs2_s;
    logic signed [DATA_W-1:0] w_b_s;
    logic       [SHAMT_W-1:0] w_shamt;
    logic        [ADDR_W-1:0] w_pc4;
    logic        [ADDR_W-1:0] w_target;

    assign w_op     = op_e'(i_op);
    assign w_b      = uses_imm(w_op) ? i_imm : i_rs2;
    assign w_rs1_s  = i_rs1;
    assign w_rs2_s  = i_rs2;
    assign w_b_s    = w_b;
    assign w_shamt  = w_b[SHAMT_W-1:0];
    assign w_pc4    = i_pc + ADDR_W'(4);
    assign w_target = i_pc + ADDR_W'(i_imm);

    always_comb begin
        o_result    = '0;
        o_jump      = 1'b0;
        o_jump_addr = w_pc4;
        case (w_op)
            OP_ADD, OP_ADDI:   o_result = i_rs1 + w_b;
            OP_SUB:            o_result = i_rs1 - i_rs2;
            OP_AND, OP_ANDI:   o_result = i_rs1 & w_b;
            OP_OR,  OP_ORI:    o_result = i_rs1 | w_b;
            OP_XOR, OP_XORI:   o_result = i_rs1 ^ w_b;
            OP_SLL, OP_SLLI:   o_result = i_rs1 << w_shamt;
            OP_SRL, OP_SRLI:   o_result = i_rs1 >> w_shamt;
            OP_SRA, OP_SRAI:   o_result = w_rs1_s >>> w_shamt;
            OP_SLT, OP_SLTI:   o_result = DATA_W'(w_rs1_s < w_b_s);
            OP_SLTU, OP_SLTIU: o_result = DATA_W'(i_rs1 < w_b);
            OP_LUI:            o_result = i_imm;
            OP_AUIPC:          o_result = DATA_W'(w_target);
            OP_JAL: begin
                o_result    = DATA_W'(w_pc4);
                o_jump      = 1'b1;
                o_jump_addr = w_target;
            end
            OP_JALR: begin
                o_result    = DATA_W'(w_pc4);
                o_jump      = 1'b1;
                o_jump_addr = ADDR_W'(i_rs1 + i_imm) & ~ADDR_W'(1);
            end
            OP_BEQ:  o_jump = (i_rs1 == i_rs2);
            OP_BNE:  o_jump = (i_rs1 != i_rs2);
            OP_BLT:  o_jump = (w_rs1_s <  w_rs2_s);
            OP_BGE:  o_jump = (w_rs1_s >= w_rs2_s);
            OP_BLTU: o_jump = (i_rs1 <  i_rs2);
            OP_BGEU: o_jump = (i_rs1 >= i_rs2);
            default: ;
        endcase
        if (is_branch(w_op) && o_jump) begin
            o_jump_addr = w_target;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: registers the combinational datapath onto the result bus with one cycle
// of latency; flush drops the pending pulse, rdy_in low freezes the whole stage.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W    = PKG_DATA_W,
    parameter int ADDR_W    = PKG_ADDR_W,
    parameter int ROB_IDX_W = PKG_ROB_IDX_W,
    parameter int OP_W      = PKG_OP_W
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 rs_to_alu_ready,
    input  logic [OP_W-1:0]      rs_to_alu_op,
    input  logic [DATA_W-1:0]    rs_to_alu_rs1,
    input  logic [DATA_W-1:0]    rs_to_alu_rs2,
    input  logic [ROB_IDX_W-1:0] rs_to_alu_rob_index,
    input  logic [ADDR_W-1:0]    rs_to_alu_PC,
    input  logic [DATA_W-1:0]    rs_to_alu_imm,
    output logic                 alu_ready,
    output logic [DATA_W-1:0]    alu_result,
    output logic [ROB_IDX_W-1:0] alu_rob_index,
    output logic                 alu_jump,
    output logic [ADDR_W-1:0]    alu_jump_addr
);
    logic [DATA_W-1:0]    w_result;
    logic                 w_jump;
    logic [ADDR_W-1:0]    w_jump_addr;

    logic                 r_ready_p0;
    logic [DATA_W-1:0]    r_result_p0;
    logic [ROB_IDX_W-1:0] r_rob_index_p0;
    logic                 r_jump_p0;
    logic [ADDR_W-1:0]    r_jump_addr_p0;

    alu_exec_comb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) u_comb (
        .i_op        (rs_to_alu_op),
        .i_rs1       (rs_to_alu_rs1),
        .i_rs2       (rs_to_alu_rs2),
        .i_imm       (rs_to_alu_imm),
        .i_pc        (rs_to_alu_PC),
        .o_result    (w_result),
        .o_jump      (w_jump),
        .o_jump_addr (w_jump_addr)
    );

    // Issue -> result-bus stage boundary
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_ready_p0     <= 1'b0;
            r_result_p0    <= '0;
            r_rob_index_p0 <= '0;
            r_jump_p0      <= 1'b0;
            r_jump_addr_p0 <= '0;
        end else if (clr_in) begin
            r_ready_p0 <= 1'b0;
        end else if (rdy_in) begin
            r_ready_p0 <= rs_to_alu_ready;
            if (rs_to_alu_ready) begin
                r_result_p0    <= w_result;
                r_rob_index_p0 <= rs_to_alu_rob_index;
                r_jump_p0      <= w_jump;
                r_jump_addr_p0 <= w_jump_addr;
            end
        end
    end

    assign alu_ready     = r_ready_p0;
    assign alu_result    = r_result_p0;
    assign alu_rob_index = r_rob_index_p0;
    assign alu_jump      = r_jump_p0;
    assign alu_jump_addr = r_jump_addr_p0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, hand-written flush/stall/reset sequences,
// and randomized traffic against a behavioural model of the result bus.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clr_in;
    logic        rs_to_alu_ready;
    logic [5:0]  rs_to_alu_op;
    logic [31:0] rs_to_alu_rs1;
    logic [31:0] rs_to_alu_rs2;
    logic [3:0]  rs_to_alu_rob_index;
    logic [31:0] rs_to_alu_PC;
    logic [31:0] rs_to_alu_imm;
    logic        alu_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_rob_index;
    logic        alu_jump;
    logic [31:0] alu_jump_addr;

    int checks = 0;
    int errors = 0;

    // expected state of the result bus
    logic        m_ready;
    logic [31:0] m_result;
    logic [3:0]  m_tag;
    logic        m_jump;
    logic [31:0] m_addr;

    alu_exec_unit dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .clr_in              (clr_in),
        .rs_to_alu_ready     (rs_to_alu_ready),
        .rs_to_alu_op        (rs_to_alu_op),
        .rs_to_alu_rs1       (rs_to_alu_rs1),
        .rs_to_alu_rs2       (rs_to_alu_rs2),
        .rs_to_alu_rob_index (rs_to_alu_rob_index),
        .rs_to_alu_PC        (rs_to_alu_PC),
        .rs_to_alu_imm       (rs_to_alu_imm),
        .alu_ready           (alu_ready),
        .alu_result          (alu_result),
        .alu_rob_index       (alu_rob_index),
        .alu_jump            (alu_jump),
        .alu_jump_addr       (alu_jump_addr)
    );

    always #5 clk_in = ~clk_in;

    function automatic void ref_exec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] pc, input logic [31:0] imm,
                                     output logic [31:0] res, output logic jmp, output logic [31:0] nxt);
        logic [31:0] opb;
        logic [63:0] ext;
        logic        cond;
        logic        is_i;
        is_i = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) ||
               (op == OP_SLLI) || (op == OP_SRLI) || (op == OP_SRAI) || (op == OP_SLTI) ||
               (op == OP_SLTIU);
        opb  = is_i ? imm : b;
        ext  = {{32{a[31]}}, a} >> opb[4:0];
        res  = 32'd0;
        jmp  = 1'b0;
        nxt  = pc + 32'd4;
        cond = 1'b0;
        case (op)
            OP_ADD, OP_ADDI:   res = a + opb;
            OP_SUB:            res = a - b;
            OP_AND, OP_ANDI:   res = a & opb;
            OP_OR,  OP_ORI:    res = a | opb;
            OP_XOR, OP_XORI:   res = a ^ opb;
            OP_SLL, OP_SLLI:   res = a << opb[4:0];
            OP_SRL, OP_SRLI:   res = a >> opb[4:0];
            OP_SRA, OP_SRAI:   res = ext[31:0];
            OP_SLT, OP_SLTI:   res = (int'(a) < int'(opb)) ? 32'd1 : 32'd0;
            OP_SLTU, OP_SLTIU: res = (a < opb) ? 32'd1 : 32'd0;
            OP_LUI:            res = imm;
            OP_AUIPC:          res = pc + imm;
            OP_JAL:  begin res = pc + 32'd4; jmp = 1'b1; nxt = pc + imm; end
            OP_JALR: begin res = pc + 32'd4; jmp = 1'b1; nxt = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ:  cond = (a == b);
                    OP_BNE:  cond = (a != b);
                    OP_BLT:  cond = (int'(a) < int'(b));
                    OP_BGE:  cond = (int'(a) >= int'(b));
                    OP_BLTU: cond = (a < b);
                    default: cond = (a >= b);
                endcase
                jmp = cond;
                nxt = cond ? pc + imm : pc + 32'd4;
            end
            default: ;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".ready"}, {31'd0, alu_ready}, {31'd0, m_ready});
        if (m_ready) begin
            chk({nm, ".result"}, alu_result, m_result);
            chk({nm, ".tag"},    {28'd0, alu_rob_index}, {28'd0, m_tag});
            chk({nm, ".jump"},   {31'd0, alu_jump}, {31'd0, m_jump});
            chk({nm, ".addr"},   alu_jump_addr, m_addr);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0; m_result = '0; m_tag = '0; m_jump = 1'b0; m_addr = '0;
    endtask

    // advance the model by the inputs presented, then clock the DUT and settle
    task automatic tick();
        logic [31:0] r;
        logic        j;
        logic [31:0] n;
        if (clr_in) begin
            m_ready = 1'b0;
        end else if (rdy_in) begin
            m_ready = rs_to_alu_ready;
            if (rs_to_alu_ready) begin
                ref_exec(rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_PC, rs_to_alu_imm, r, j, n);
                m_result = r; m_jump = j; m_addr = n; m_tag = rs_to_alu_rob_index;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tag);
        rs_to_alu_ready = 1'b1; rs_to_alu_op = op; rs_to_alu_rs1 = a; rs_to_alu_rs2 = b;
        rs_to_alu_PC = pc; rs_to_alu_imm = imm; rs_to_alu_rob_index = tag;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".ready"},  {31'd0, alu_ready}, 32'd0);
        chk({nm, ".result"}, alu_result, 32'd0);
        chk({nm, ".tag"},    {28'd0, alu_rob_index}, 32'd0);
        chk({nm, ".jump"},   {31'd0, alu_jump}, 32'd0);
        chk({nm, ".addr"},   alu_jump_addr, 32'd0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs1, rs2, pc, imm;
        logic [31:0] res;
        logic        jmp;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{OP_ADD,   32'd5,          32'd7,          32'h1000, 32'd0,          32'd12,         1'b0, 32'h1004};
        vecs[1]  = '{OP_SUB,   32'd5,          32'd7,          32'h1000, 32'd0,          32'hFFFF_FFFE,  1'b0, 32'h1004};
        vecs[2]  = '{OP_SLT,   32'hFFFF_FFFF,  32'd1,          32'h0,    32'd0,          32'd1,          1'b0, 32'h4};
        vecs[3]  = '{OP_SLTU,  32'hFFFF_FFFF,  32'd1,          32'h0,    32'd0,          32'd0,          1'b0, 32'h4};
        vecs[4]  = '{OP_SRAI,  32'h8000_0000,  32'd0,          32'h0,    32'h21,         32'hC000_0000,  1'b0, 32'h4};
        vecs[5]  = '{OP_BNE,   32'd3,          32'd3,          32'h100,  32'h20,         32'd0,          1'b0, 32'h104};
        vecs[6]  = '{OP_BLT,   32'hFFFF_FFFF,  32'd0,          32'h100,  32'h20,         32'd0,          1'b1, 32'h120};
        vecs[7]  = '{OP_JALR,  32'h203,        32'd0,          32'h40,   32'd0,          32'h44,         1'b1, 32'h202};
        vecs[8]  = '{OP_JAL,   32'd0,          32'd0,          32'h200,  32'hFFFF_FFF0,  32'h204,        1'b1, 32'h1F0};
        vecs[9]  = '{OP_LUI,   32'd9,          32'd9,          32'h0,    32'h1234_5000,  32'h1234_5000,  1'b0, 32'h4};
        vecs[10] = '{OP_AUIPC, 32'd0,          32'd0,          32'h1000, 32'h2000,       32'h3000,       1'b0, 32'h1004};
        vecs[11] = '{6'h3F,    32'd1,          32'd2,          32'h10,   32'h40,         32'd0,          1'b0, 32'h14};
        vecs[12] = '{OP_BGEU,  32'd1,          32'hFFFF_FFFF,  32'h100,  32'h20,         32'd0,          1'b0, 32'h104};
        vecs[13] = '{OP_SLL,   32'd1,          32'h25,         32'h0,    32'd0,          32'h20,         1'b0, 32'h4};
        vecs[14] = '{OP_XORI,  32'hF0F0,       32'd0,          32'h0,    32'hFFFF,       32'h0F0F,       1'b0, 32'h4};
        vecs[15] = '{OP_BGE,   32'hFFFF_FFFF,  32'd0,          32'h100,  32'h20,         32'd0,          1'b0, 32'h104};

        rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
        issue(OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd1);
        rs_to_alu_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk_all_zero("reset");
        rst_in = 1'b1;
        tick();
        chk_model("idle_after_reset");
        chk("idle_ready", {31'd0, alu_ready}, 32'd0);

        // directed table
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm, 4'((i % 15) + 1));
            tick();
            chk($sformatf("vec%0d.ready", i),  {31'd0, alu_ready}, 32'd1);
            chk($sformatf("vec%0d.result", i), alu_result, vecs[i].res);
            chk($sformatf("vec%0d.tag", i),    {28'd0, alu_rob_index}, 32'((i % 15) + 1));
            chk($sformatf("vec%0d.jump", i),   {31'd0, alu_jump}, {31'd0, vecs[i].jmp});
            chk($sformatf("vec%0d.addr", i),   alu_jump_addr, vecs[i].addr);
        end
        rs_to_alu_ready = 1'b0;
        tick();
        chk("table_drain_ready", {31'd0, alu_ready}, 32'd0);

        // back-to-back ADD/SUB then mid-stream async reset
        issue(OP_ADD, 32'd5, 32'd7, 32'h0, 32'd0, 4'd3);
        tick();
        chk("b2b0.ready", {31'd0, alu_ready}, 32'd1);
        chk("b2b0.result", alu_result, 32'd12);
        chk("b2b0.tag", {28'd0, alu_rob_index}, 32'd3);
        issue(OP_SUB, 32'd5, 32'd7, 32'h0, 32'd0, 4'd4);
        tick();
        chk("b2b1.ready", {31'd0, alu_ready}, 32'd1);
        chk("b2b1.result", alu_result, 32'hFFFF_FFFE);
        chk("b2b1.tag", {28'd0, alu_rob_index}, 32'd4);
        rs_to_alu_ready = 1'b0;
        #1 rst_in = 1'b0;
        #1;
        model_reset();
        chk_all_zero("async_reset");
        rst_in = 1'b1;
        tick();
        chk("post_reset_ready", {31'd0, alu_ready}, 32'd0);

        // flush: issue with clr in the same cycle, then clr the cycle after
        issue(OP_ADD, 32'd1, 32'd2, 32'h0, 32'd0, 4'd7);
        clr_in = 1'b1;
        tick();
        chk("flush_same.ready", {31'd0, alu_ready}, 32'd0);
        clr_in = 1'b0;
        tick();
        chk("flush_next.pulse", {31'd0, alu_ready}, 32'd1);
        rs_to_alu_ready = 1'b0;
        clr_in = 1'b1;
        tick();
        chk("flush_next.ready", {31'd0, alu_ready}, 32'd0);
        clr_in = 1'b0;

        // stall: outputs frozen while rdy_in is low even with a new issue pending
        issue(OP_ADD, 32'd10, 32'd20, 32'h300, 32'd0, 4'd5);
        tick();
        issue(OP_SUB, 32'd1, 32'd1, 32'h500, 32'd0, 4'd6);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d.ready", k),  {31'd0, alu_ready}, 32'd1);
            chk($sformatf("stall%0d.result", k), alu_result, 32'd30);
            chk($sformatf("stall%0d.tag", k),    {28'd0, alu_rob_index}, 32'd5);
            chk($sformatf("stall%0d.addr", k),   alu_jump_addr, 32'h304);
        end
        rdy_in = 1'b1;
        rs_to_alu_ready = 1'b0;
        tick();
        chk("stall_release.ready", {31'd0, alu_ready}, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rs_to_alu_ready     = ($urandom_range(0, 3) != 0);
            rs_to_alu_op        = 6'($urandom_range(0, 31));
            rs_to_alu_rs1       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            rs_to_alu_rs2       = ($urandom_range(0, 3) == 0) ? rs_to_alu_rs1 : $urandom;
            rs_to_alu_PC        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rs_to_alu_imm       = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            rs_to_alu_rob_index = 4'($urandom_range(1, 15));
            clr_in              = ($urandom_range(0, 15) == 0);
            rdy_in              = ($urandom_range(0, 7) != 0);
            tick();
            chk_model($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
